// File: rtl/rain_pkg.sv
// Shared types and constants for the glyph-rain column sequencer.
// Random respawn speed is enabled by defining RAIN_SCHED_RESPAWN_RANDOM_EN.
package rain_pkg;

  localparam int NCOLS_DEF    = 80;
  localparam int WRAP_ROW_DEF = 47;

  // Fibonacci LFSR x^8+x^6+x^5+x^4+1: feedback is XOR of bits 7,5,4,3
  localparam logic [7:0] LFSR_SEED = 8'hA5;
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  typedef enum logic [1:0] {IDLE, SWEEP, DONE} state_t;

  typedef struct packed {
    logic [5:0] head;
    logic [1:0] speed;
    logic [1:0] ph;
  } col_t;

  // One frame step of a column: phase accumulator carries into the head row;
  // a carry at the wrap row respawns the column at the top with a new speed.
  function automatic col_t col_step(col_t c, logic [1:0] rsp_speed, logic [5:0] wrap);
    logic [2:0] sum;
    col_t       n;
    sum  = {1'b0, c.ph} + {1'b0, c.speed} + 3'd1;
    n    = c;
    n.ph = sum[1:0];
    if (sum[2]) begin
      if (c.head == wrap) begin
        n.head  = '0;
        n.ph    = '0;
        n.speed = rsp_speed;
      end else begin
        n.head = c.head + 6'd1;
      end
    end
    return n;
  endfunction

endpackage

// File: rtl/rain_lfsr8.sv
// 8-bit Fibonacci LFSR supplying random respawn speeds.
// Only built when RAIN_SCHED_RESPAWN_RANDOM_EN is defined.
`ifdef RAIN_SCHED_RESPAWN_RANDOM_EN
module rain_lfsr8
  import rain_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  output logic [7:0] q
);

  // Shift left, feedback from the tap mask into bit 0
  always_ff @(posedge clk or posedge reset) begin
    if (reset)   q <= LFSR_SEED;
    else if (en) q <= {q[6:0], ^(q & LFSR_TAPS)};
  end

endmodule
`endif

// File: rtl/rain_column_sched.sv
// Per-column head/speed/phase sequencer for the glyph-rain display.
// All columns advance once per frame in a sweep started by frame_start;
// a registered lookup serves the pixel datapath every cycle.
// Define RAIN_SCHED_RESPAWN_RANDOM_EN for LFSR-driven respawn speeds,
// otherwise a respawning column takes speed (old + 1) mod 4.
module rain_column_sched
  import rain_pkg::*;
#(
  parameter int NCOLS    = NCOLS_DEF,
  parameter int WRAP_ROW = WRAP_ROW_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_start,
  input  logic       freeze,
  input  logic [6:0] col_idx,
  output logic [5:0] head_row,
  output logic [1:0] col_speed,
  output logic       busy,
  output logic       update_done,
  output logic       overrun
);

  localparam int IW = $clog2(NCOLS);

  state_t        state;
  logic [IW-1:0] idx;
  col_t          col_q [NCOLS];
  logic [1:0]    rnd_speed;

`ifdef RAIN_SCHED_RESPAWN_RANDOM_EN
  logic [7:0] lfsr_q;
  logic       unused_lfsr;

  rain_lfsr8 u_lfsr (
    .clk   (clk),
    .reset (reset),
    .en    (state == SWEEP),
    .q     (lfsr_q)
  );

  assign rnd_speed   = lfsr_q[1:0];
  assign unused_lfsr = ^lfsr_q[7:2];
`else
  assign rnd_speed = 2'b00;
`endif

  // Sweep sequencer: IDLE -> SWEEP (one column per cycle) -> DONE -> IDLE
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      idx         <= '0;
      busy        <= 1'b0;
      update_done <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      update_done <= 1'b0;
      case (state)
        IDLE: if (frame_start && !freeze) begin
          state <= SWEEP;
          idx   <= '0;
          busy  <= 1'b1;
        end
        SWEEP: begin
          idx <= idx + 1'b1;
          if (idx == IW'(NCOLS - 1)) begin
            state       <= DONE;
            busy        <= 1'b0;
            update_done <= 1'b1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
      // A frame pulse landing on a running sweep is dropped but remembered
      if (frame_start && state != IDLE) overrun <= 1'b1;
    end
  end

  // Per-column state, written only in the sweep cycle that selects it
  for (genvar i = 0; i < NCOLS; i++) begin : g_col
    col_t       c_q;
    logic [1:0] rsp;

`ifdef RAIN_SCHED_RESPAWN_RANDOM_EN
    assign rsp = rnd_speed;
`else
    assign rsp = c_q.speed + 2'd1;
`endif

    // Reset speed staggers columns by index so the rain starts uneven
    always_ff @(posedge clk or posedge reset) begin
      if (reset)
        c_q <= '{head: 6'd0, speed: 2'(i), ph: 2'd0};
      else if (state == SWEEP && idx == IW'(i))
        c_q <= col_step(c_q, rsp, 6'(WRAP_ROW));
    end

    assign col_q[i] = c_q;
  end

`ifndef RAIN_SCHED_RESPAWN_RANDOM_EN
  logic unused_rnd;
  assign unused_rnd = ^rnd_speed;
`endif

  // Registered lookup; reads see pre-update state, out-of-range reads 0
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_row  <= '0;
      col_speed <= '0;
    end else if (int'(col_idx) < NCOLS) begin
      head_row  <= col_q[col_idx].head;
      col_speed <= col_q[col_idx].speed;
    end else begin
      head_row  <= '0;
      col_speed <= '0;
    end
  end

endmodule

// File: doc/rain_column_sched.md
# rain_column_sched

Per-column state sequencer for the glyph-rain display. It keeps a head row, speed and phase for every 8-pixel text column, advances all columns once per frame during vertical blanking, and serves a registered per-column lookup to the pixel datapath during active video. The pixel datapath uses the looked-up head row instead of deriving motion from the frame counter.

## Interface
Parameters:
- NCOLS, 80: number of columns; indices 0..NCOLS-1.
- WRAP_ROW, 47: last head row before respawn; covers 40 visible rows plus an 8-row tail.

Ports (one clock; reset is asynchronous and active-high):
- clk  in  1  pixel clock.
- reset  in  1  asynchronous active-high reset.
- frame_start  in  1  single-cycle pulse at vblank start.
- freeze  in  1  when high, frame_start is ignored and state is held.
- col_idx  in  7  lookup column (x_block).
- head_row  out  6  head row of col_idx, registered.
- col_speed  out  2  speed of col_idx, registered.
- busy  out  1  update sweep in progress.
- update_done  out  1  one-cycle pulse when a sweep completes.
- overrun  out  1  sticky; set when frame_start arrives while busy.

## Operation
- Per column i: head[5:0], speed[1:0], ph[1:0].
- Reset values:
  - head = 0, speed = i[1:0], ph = 0 for every i.
  - All outputs 0; FSM in IDLE; LFSR = 8'hA5.
- FSM states:
  - IDLE: on frame_start & ~freeze, clear idx and go to SWEEP.
  - SWEEP: process column idx, idx++. After idx == NCOLS-1, go to DONE.
  - DONE: pulse update_done for one cycle, then go to IDLE.
- Column update arithmetic, 3-bit: sum = ph + speed + 1; carry = sum[2]; ph <= sum[1:0].
- carry & head != WRAP_ROW: head <= head+1.
- carry & head == WRAP_ROW: respawn.
  - head <= 0; ph <= 0.
  - speed <= respawn value (see Configuration).
- No carry: head is unchanged.
- Resulting rates: speed 3 advances every frame; speed 0 advances every 4th frame.
- frame_start in SWEEP or DONE is ignored and sets overrun. overrun clears only on reset.
- freeze has no effect on a sweep already in progress.
- Lookup behaviour:
  - Registered every cycle in all states.
  - col_idx >= NCOLS returns head_row = 0, col_speed = 0.
  - Read and write of the same column in the same cycle returns the pre-update value.
- Reset asserted mid-sweep: the sweep aborts immediately and all state returns to its reset values. Columns already updated are also reset.

## Timing
- frame_start sampled in IDLE at edge T:
  - busy is high for cycles T+1..T+NCOLS.
  - Column k is written at edge T+1+k.
  - update_done is high in cycle T+NCOLS+1.
  - The FSM is back in IDLE at T+NCOLS+2.
- Sweep length is NCOLS+1 cycles, far shorter than the 45-line vblank.
- Lookup latency: 1 cycle from col_idx to head_row/col_speed.

## Configuration
- RAIN_SCHED_RESPAWN_RANDOM_EN defined:
  - 8-bit Fibonacci LFSR, taps x^8+x^6+x^5+x^4+1, seed 8'hA5.
  - Steps once per SWEEP cycle.
  - Respawn speed = lfsr[1:0].
- Undefined:
  - No LFSR is instantiated.
  - Respawn speed = (old speed + 1) mod 4.

## Structure
- Package rain_pkg holds:
  - NCOLS and WRAP_ROW defaults.
  - LFSR seed and tap constants.
  - State enum {IDLE, SWEEP, DONE}.
  - Column-state struct {head, speed, ph}.
- Sub-module rain_lfsr8: enable, state output, async reset to seed. Compiled only under the macro.

## Test plan
- Reset: all columns read back head 0 and speed i[1:0] (col 5 -> speed 1); busy, update_done and overrun are 0.
- Single sweep with frame_start at T: busy is high for 80 cycles, update_done pulses at T+81, and col 3 (speed 3) reads head 1 afterwards.
- Four frames: col 0 (speed 0) reads head 1; col 3 reads head 4.
- Wrap: preload col 3 to head 47 via 47 frames; next frame gives head 0, ph 0. Respawn speed is 0 without the macro and lfsr[1:0] with it.
- frame_start asserted at T+10 during a sweep: it is ignored, overrun becomes 1, and the sweep ends at T+81. frame_start with freeze=1: no sweep starts and state is unchanged.
- col_idx = 85: head_row 0, col_speed 0. Reset asserted at T+40: busy is 0 immediately and col 2 reads head 0, speed 2.
